seq_restoring_divider: RTL

- Sequential restoring divider, the inverse operation of the team's recursive 2*DW-bit-product multipliers.
- Divides a 2*DW-bit dividend by a DW-bit divisor and returns a 2*DW-bit quotient and a DW-bit remainder.
- Produces one quotient bit per clock.
- Sits after the multiplier datapath for product-recovery and error-analysis checks; valid/ready handshakes on both sides.

---
 rtl/seq_restoring_divider.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2*DW-bit unsigned dividend / DW-bit unsigned
// divisor. It produces one quotient bit per clock and uses valid/ready
// handshakes on both the input and output side.
module seq_restoring_divider #(
  parameter int unsigned DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            busy
);

  localparam int unsigned QW = 2 * DW;
  localparam int unsigned CW = $clog2(QW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [QW-1:0]   shreg;      // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [DW-1:0]   dvsr;
  logic [DW-1:0]   prem;       // partial remainder; stays below dvsr between iterations
  logic [CW-1:0]   cnt;

  logic [DW:0]     shifted;
  logic [DW:0]     trial;
  logic            qbit;
  logic [DW-1:0]   prem_next;
  logic [QW-1:0]   shreg_next;

  // One restoring step. The DW+1-bit shifted value is the full partial
  // remainder. Because prem < dvsr, a non-negative trial always fits in DW
  // bits. When the trial goes negative, its wrapped value keeps the top bit set.
  always_comb begin
    shifted    = {prem, shreg[QW-1]};
    trial      = shifted - {1'b0, dvsr};
    qbit       = ~trial[DW];
    prem_next  = qbit ? trial[DW-1:0] : shifted[DW-1:0];
    shreg_next = {shreg[QW-2:0], qbit};
  end

  // Control FSM and datapath registers. Handshake outputs are registered decodes of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      dvsr        <= '0;
      prem        <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= dividend;
            dvsr     <= divisor;
            prem     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[DW-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          shreg <= shreg_next;
          prem  <= prem_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(QW - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= shreg_next;
            remainder <= prem_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
